// File: rtl/vc_iter_shifter_if.sv
// Purpose: groups the request (istream) and result (ostream) val/rdy streams of the iterative shifter.
// Latency: none, this is wiring only.
// Backpressure: the master drives ostream_rdy and the slave drives istream_rdy.
interface vc_iter_shifter_if #(
   parameter int p_nbits       = 32,
   parameter int p_shamt_nbits = $clog2(p_nbits)
);
   logic                     istream_val;
   logic                     istream_rdy;
   logic [p_nbits-1:0]       istream_data;
   logic [p_shamt_nbits-1:0] istream_shamt;
   logic [1:0]               istream_mode;
   logic                     ostream_val;
   logic                     ostream_rdy;
   logic [p_nbits-1:0]       ostream_data;

   // The requester, and the consumer of results.
   modport master (
      output istream_val,
      output istream_data,
      output istream_shamt,
      output istream_mode,
      input  istream_rdy,
      input  ostream_val,
      input  ostream_data,
      output ostream_rdy
   );

   // The shifter itself.
   modport slave (
      input  istream_val,
      input  istream_data,
      input  istream_shamt,
      input  istream_mode,
      output istream_rdy,
      output ostream_val,
      output ostream_data,
      input  ostream_rdy
   );
endinterface

// File: rtl/vc_iter_shifter.sv
// Purpose: iterative SLL/SRL/SRA/ROTR shifter that moves at most p_step bits per cycle.
// Latency: 1 + ceil(shamt/p_step) cycles from the accept edge to ostream_val.
// Backpressure: one op in flight; the result is held in DONE until ostream_rdy, and istream_rdy is low meanwhile.
module vc_iter_shifter #(
   parameter int p_nbits       = 32,
   parameter int p_shamt_nbits = $clog2(p_nbits),
   parameter int p_step        = 4
) (
   input  logic              clk,
   input  logic              reset,
   vc_iter_shifter_if.slave  io
);

   localparam logic [1:0] MODE_SLL  = 2'b00;
   localparam logic [1:0] MODE_SRL  = 2'b01;
   localparam logic [1:0] MODE_SRA  = 2'b10;

   // Per-cycle step clipped to the shift-amount width.  When p_step equals
   // p_nbits this truncates to zero, but then rem is always below p_step and
   // the clipped value is never selected.
   localparam logic [p_shamt_nbits-1:0] STEP_K  = p_shamt_nbits'(p_step);
   localparam logic [p_shamt_nbits:0]   STEP_W  = (p_shamt_nbits+1)'(p_step);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                   state;
   logic [p_shamt_nbits-1:0] rem;
   logic [p_nbits-1:0]       res;
   logic [1:0]               mode;
   logic                     val_q;

   logic [p_shamt_nbits-1:0] k;
   logic [p_shamt_nbits-1:0] k_neg;
   logic [p_nbits-1:0]       res_step;

   // Step size for this cycle: the whole remainder, or p_step if more is left.
   always_comb begin
      k = rem;
      if ({1'b0, rem} > STEP_W) begin
         k = STEP_K;
      end
   end

   // Left-shift amount that completes a right-rotate by k.  In CALC, k is
   // never zero, so this equals p_nbits - k.
   assign k_neg = ~k + p_shamt_nbits'(1);

   // One partial shift of the result register in the latched mode.  For SRA
   // the sign bit never changes, so replicating the current MSB is the same as
   // replicating the operand's original MSB.
   always_comb begin
      res_step = res;
      case (mode)
         MODE_SLL: res_step = res << k;
         MODE_SRL: res_step = res >> k;
         MODE_SRA: res_step = $signed(res) >>> k;
         default:  res_step = (res >> k) | (res << k_neg);
      endcase
   end

   // Control FSM and datapath registers.  ostream_val is registered alongside
   // the state so that it depends on state only.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         rem   <= '0;
         res   <= '0;
         mode  <= 2'b00;
         val_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (io.istream_val) begin
                  res  <= io.istream_data;
                  mode <= io.istream_mode;
                  rem  <= io.istream_shamt;
                  if (io.istream_shamt == '0) begin
                     state <= S_DONE;
                     val_q <= 1'b1;
                  end else begin
                     state <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               res <= res_step;
               rem <= rem - k;
               if (rem == k) begin
                  state <= S_DONE;
                  val_q <= 1'b1;
               end
            end
            S_DONE: begin
               if (io.ostream_rdy) begin
                  state <= S_IDLE;
                  val_q <= 1'b0;
               end
            end
            default: begin
               state <= S_IDLE;
               val_q <= 1'b0;
            end
         endcase
      end
   end

   // Ready is held low during reset so that nothing is accepted while the
   // block is being cleared.
   assign io.istream_rdy  = (state == S_IDLE) && !reset;
   assign io.ostream_val  = val_q;
   assign io.ostream_data = res;

endmodule

// File: tb/tb_vc_iter_shifter.sv
// Purpose: directed and random checks of vc_iter_shifter at p_step=4 and p_step=1, scoreboard based.
// Latency: checks ostream_val arrives exactly 1 + ceil(shamt/p_step) cycles after accept.
// Backpressure: holds ostream_rdy low in DONE and checks the result and istream_rdy stay put.
module tb_vc_iter_shifter;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   vc_iter_shifter_if #(.p_nbits(32)) s4 ();
   vc_iter_shifter_if #(.p_nbits(32)) s1 ();

   vc_iter_shifter #(.p_nbits(32), .p_step(4)) dut (
      .clk   (clk),
      .reset (reset),
      .io    (s4)
   );

   vc_iter_shifter #(.p_nbits(32), .p_step(1)) dut1 (
      .clk   (clk),
      .reset (reset),
      .io    (s1)
   );

   int compared   = 0;
   int mismatched = 0;
   logic [31:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      compared++;
      assert (obs === expv) else begin
         mismatched++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
      end
   endtask

   function automatic logic [31:0] ref_shift(input logic [1:0] m, input logic [31:0] d, input int sh);
      logic [31:0] r;
      case (m)
         2'd0:    r = d << sh;
         2'd1:    r = d >> sh;
         2'd2:    r = $signed(d) >>> sh;
         default: r = (sh == 0) ? d : ((d >> sh) | (d << (32 - sh)));
      endcase
      return r;
   endfunction

   task automatic pop_check(input string tag, input logic [31:0] obs);
      logic [31:0] expv;
      if (exp_q.size() == 0) begin
         compared++;
         mismatched++;
         $error("FAIL %s: observed 0x%08h expected <scoreboard empty>", tag, obs);
      end else begin
         expv = exp_q.pop_front();
         check(tag, obs, expv);
      end
   endtask

   // Full request/response on the p_step=4 instance.
   task automatic run_op(input string tag, input logic [1:0] m, input logic [4:0] sh,
                         input logic [31:0] d, input logic [31:0] expv, input int lat, input int hold);
      int n;
      logic [31:0] held;
      n = 0;
      while (!s4.istream_rdy && n < 50) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_in_rdy"}, s4.istream_rdy, 32'd1);
      s4.istream_val   = 1'b1;
      s4.istream_mode  = m;
      s4.istream_shamt = sh;
      s4.istream_data  = d;
      @(posedge clk);
      exp_q.push_back(expv);
      @(negedge clk);
      s4.istream_val   = 1'b0;
      s4.istream_data  = $urandom;
      s4.istream_shamt = 5'($urandom_range(0, 31));
      n = 1;
      while (!s4.ostream_val && n < 100) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_latency"}, n, lat);
      held = s4.ostream_data;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check({tag, "_hold_data"}, s4.ostream_data, held);
         check({tag, "_hold_in_rdy"}, s4.istream_rdy, 32'd0);
         check({tag, "_hold_val"}, s4.ostream_val, 32'd1);
      end
      pop_check({tag, "_data"}, s4.ostream_data);
      s4.ostream_rdy = 1'b1;
      @(posedge clk);
      @(negedge clk);
      s4.ostream_rdy = 1'b0;
      check({tag, "_val_after_hs"}, s4.ostream_val, 32'd0);
      check({tag, "_idle_after_hs"}, s4.istream_rdy, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      logic seen;
      logic [1:0] m;
      int sh;
      logic [31:0] d;

      reset = 1'b1;
      s4.istream_val = 1'b0; s4.istream_data = '0; s4.istream_shamt = '0; s4.istream_mode = '0;
      s4.ostream_rdy = 1'b0;
      s1.istream_val = 1'b0; s1.istream_data = '0; s1.istream_shamt = '0; s1.istream_mode = '0;
      s1.ostream_rdy = 1'b0;

      repeat (3) @(negedge clk);
      check("rst_in_rdy", s4.istream_rdy, 32'd0);
      check("rst_out_val", s4.ostream_val, 32'd0);
      check("rst_out_data", s4.ostream_data, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_in_rdy", s4.istream_rdy, 32'd1);
      check("post_rst_out_val", s4.ostream_val, 32'd0);
      check("post_rst_out_data", s4.ostream_data, 32'd0);
      check("post_rst_in_rdy_s1", s1.istream_rdy, 32'd1);

      // Directed cases.
      run_op("sll31",  2'd0, 5'd31, 32'h0000_0001, 32'h8000_0000, 9, 0);
      run_op("sra4",   2'd2, 5'd4,  32'h8000_0000, 32'hF800_0000, 2, 0);
      run_op("sra5",   2'd2, 5'd5,  32'h7000_0000, 32'h0380_0000, 3, 0);
      run_op("rotr4",  2'd3, 5'd4,  32'h0000_00F1, 32'h1000_000F, 2, 0);
      run_op("srl0",   2'd1, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1, 0);
      run_op("bp_rotr9", 2'd3, 5'd9, 32'h1234_5678, 32'h3C09_1A2B, 4, 5);
      run_op("after_bp", 2'd0, 5'd8, 32'h00AB_CDEF, 32'hABCD_EF00, 3, 0);

      // Random cases against the single-shot reference.
      for (int i = 0; i < 8; i++) begin
         m  = 2'($urandom_range(0, 3));
         sh = $urandom_range(0, 31);
         d  = $urandom;
         run_op("rand", m, 5'(sh), d, ref_shift(m, d, sh), 1 + (sh + 3) / 4, 0);
      end

      // p_step = 1 instance: SLL by 7 takes 7 CALC cycles.
      n = 0;
      while (!s1.istream_rdy && n < 50) begin
         @(negedge clk);
         n++;
      end
      s1.istream_val   = 1'b1;
      s1.istream_mode  = 2'd0;
      s1.istream_shamt = 5'd7;
      s1.istream_data  = 32'h0000_0003;
      @(posedge clk);
      exp_q.push_back(32'h0000_0180);
      @(negedge clk);
      s1.istream_val = 1'b0;
      n = 1;
      while (!s1.ostream_val && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("step1_latency", n, 32'd8);
      pop_check("step1_data", s1.ostream_data);
      s1.ostream_rdy = 1'b1;
      @(posedge clk);
      @(negedge clk);
      s1.ostream_rdy = 1'b0;
      check("step1_val_after_hs", s1.ostream_val, 32'd0);

      // Reset during the third CALC cycle of SLL by 31.
      s4.istream_val   = 1'b1;
      s4.istream_mode  = 2'd0;
      s4.istream_shamt = 5'd31;
      s4.istream_data  = 32'h0000_0001;
      @(posedge clk);
      @(negedge clk);
      s4.istream_val = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("midrst_val", s4.ostream_val, 32'd0);
      check("midrst_data", s4.ostream_data, 32'd0);
      check("midrst_in_rdy", s4.istream_rdy, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check("midrst_idle", s4.istream_rdy, 32'd1);
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         seen = seen | s4.ostream_val;
         @(negedge clk);
      end
      check("midrst_no_stale", seen, 32'd0);
      run_op("post_midrst", 2'd1, 5'd13, 32'hF0F0_1234, 32'h0007_8780, 5, 0);

      check("scoreboard_empty", exp_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/vc_iter_shifter.md
# vc_iter_shifter

Parametrised, multi-cycle, multi-mode shifter with latency-insensitive val/rdy streams on input and output. It shifts or rotates a `p_nbits` operand by up to `p_step` bit positions per cycle until the requested amount is reached. It adds arithmetic-right and rotate modes to the combinational shifters in the component library. It is the shift unit used by iterative datapaths such as the multiplier and divider, where a full-width barrel shifter costs too much area.

## Interface
Parameters:
- `p_nbits`, default 32: operand width. Must be a power of two, ≥ 2.
- `p_shamt_nbits`, default `$clog2(p_nbits)`: shift-amount width. The range is 0..`p_nbits`-1.
- `p_step`, default 4: maximum bit positions shifted per cycle. Must be a power of two, 1 ≤ `p_step` ≤ `p_nbits`.

Ports:
- `clk`  in  1: the single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `istream_val`  in  1: request valid.
- `istream_rdy`  out  1: block can accept a request.
- `istream_data`  in  `p_nbits`: operand.
- `istream_shamt`  in  `p_shamt_nbits`: shift amount.
- `istream_mode`  in  2: operation select. 00 = SLL, 01 = SRL, 10 = SRA, 11 = ROTR.
- `ostream_val`  out  1: result valid.
- `ostream_rdy`  in  1: consumer accepts the result.
- `ostream_data`  out  `p_nbits`: result.

## Operation
- FSM states:
  - IDLE: `istream_rdy`=1.
  - CALC: shifting in progress.
  - DONE: `ostream_val`=1.
- IDLE transitions:
  - On `istream_val && istream_rdy`, latch data, mode and shamt. The remaining count `rem` is set to shamt.
  - If shamt ≠ 0, go to CALC. If shamt = 0, go directly to DONE.
- CALC, each cycle:
  - Compute `k = min(rem, p_step)`.
  - Shift the result register by `k` in the latched mode, then set `rem -= k`.
  - When `rem` reaches 0 on this edge, go to DONE.
- DONE: on `ostream_val && ostream_rdy`, go to IDLE.
- Mode semantics:
  - SLL: zero fill.
  - SRL: zero fill.
  - SRA: each step replicates the original bit [`p_nbits`-1].
  - ROTR: bits leaving bit 0 re-enter at bit `p_nbits`-1.
- The result equals the single-cycle shift by shamt in every mode.
- No arithmetic overflow is flagged. Bits shifted out of SLL, SRL and SRA are discarded.
- `ostream_data` is driven from the result register in all states. It is meaningful only while `ostream_val`=1, and it is held stable while `ostream_val`=1 and `ostream_rdy`=0.
- `istream_*` inputs are ignored outside IDLE.
- One request is in flight at a time; there is no input/output overlap.

## Timing
- While `reset`=1 and on the first cycle after reset:
  - state = IDLE.
  - `rem`, the result register and the latched mode are all 0.
  - `ostream_val` = 0 and `ostream_data` = 0.
  - `istream_rdy` = 0 while `reset` is high, 1 from the first cycle after deassertion.
- Latency: `ostream_val` rises `1 + ceil(shamt / p_step)` cycles after the accepting edge. With shamt = 0 the latency is 1 cycle.
- Throughput: a new request can be accepted in the cycle after the output handshake, since IDLE follows DONE. Back-to-back occupancy is therefore latency + 1 cycles per op when `ostream_rdy` is held high.
- Outputs are Moore-style: `istream_rdy` and `ostream_val` decode from state only, with no combinational path from `ostream_rdy` or `istream_val`.
- Reset asserted mid-CALC or mid-DONE: the in-flight op is abandoned and no result is produced.
- The last CALC step may be partial (`k` < `p_step`). `rem` never underflows.
- `shamt` = `p_nbits`-1 is the worst case: `ceil((p_nbits-1)/p_step)` CALC cycles.
- With `p_step` = `p_nbits`, every nonzero shift takes exactly 1 CALC cycle.

## Test plan
All directed tests use `p_nbits`=32, `p_step`=4 unless stated.
- SLL 0x0000_0001, shamt 31 → 0x8000_0000. `ostream_val` is asserted 9 cycles after the accept edge.
- SRA 0x8000_0000, shamt 4 → 0xF800_0000, latency 2.
- SRA 0x7000_0000, shamt 5 → 0x0380_0000, latency 3 (partial final step).
- ROTR 0x0000_00F1, shamt 4 → 0x1000_000F.
- SRL 0xDEAD_BEEF, shamt 0 → 0xDEAD_BEEF.
  - Latency 1, with no CALC cycle.
- Backpressure: hold `ostream_rdy`=0 for 5 cycles in DONE.
  - `ostream_data` stays stable and `istream_rdy` stays 0.
  - Release → handshake, then IDLE, then accept the next request.
  - Also check `p_step`=1, SLL shamt 7 → latency 8.
- Reset mid-operation: assert `reset` during the 3rd CALC cycle of an SLL by 31.
  - The next cycle is IDLE with `ostream_val`=0, and no stale result ever appears.
  - A fresh request after reset produces a correct result.
